// File: rtl/sum_acc_pkg.sv
// rtl/sum_acc_pkg.sv - shared widths and defaults for the block-sum accumulator
package sum_acc_pkg;

    // Incoming sum width: 8-bit adder operands plus carry.
    localparam int SUM_ACC_IN_W      = 9;
    // log2 of samples per block; legal range 1..8.
    localparam int SUM_ACC_LOG2_N    = 2;
    // Emitted-block counter width; wraps 255 -> 0.
    localparam int SUM_ACC_BLK_CNT_W = 8;

    // A block of 2**log2_n full-scale samples needs exactly log2_n extra bits.
    function automatic int sum_acc_width(input int in_w, input int log2_n);
        return in_w + log2_n;
    endfunction

    localparam int SUM_ACC_ACC_W = sum_acc_width(SUM_ACC_IN_W, SUM_ACC_LOG2_N);

endpackage

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - block-sum accumulator with valid/ready output; avg port under SUM_ACC_AVG_EN
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int  IN_W   = SUM_ACC_IN_W,
    parameter int  LOG2_N = SUM_ACC_LOG2_N,
    localparam int ACC_W  = sum_acc_width(IN_W, LOG2_N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             total,
    output logic [SUM_ACC_BLK_CNT_W-1:0] block_cnt
`ifdef SUM_ACC_AVG_EN
    ,
    output logic [IN_W-1:0]              avg
`endif
);

    // Sample index of the last sample in a block (N-1).
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    logic [LOG2_N-1:0] cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  in_data_ext;
    logic [ACC_W-1:0]  sum_next;
    logic              last_sample;
    logic              accept;

    assign in_data_ext = {{LOG2_N{1'b0}}, in_data};
    assign sum_next    = acc + in_data_ext;
    assign last_sample = (cnt == CNT_LAST);

    // Only the block-closing sample is stalled, and only while the previous total is unread.
    assign in_ready = !clr && !(last_sample && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    // Accumulate samples, publish the block total and manage the output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            total     <= '0;
            out_valid <= 1'b0;
            block_cnt <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                if (last_sample) begin
                    total     <= sum_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    block_cnt <= block_cnt + 1'b1;
                end else begin
                    acc <= sum_next;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef SUM_ACC_AVG_EN
    // Block mean, captured on the same edge as total so it shares out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            avg <= '0;
        end else if (!clr && accept && last_sample) begin
            avg <= sum_next[ACC_W-1:LOG2_N];
        end
    end
`endif

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - self-checking bench for sum_accumulator
module tb_sum_accumulator;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] total;
    logic [7:0]  block_cnt;
`ifdef SUM_ACC_AVG_EN
    logic [8:0]  avg;
`endif

    int checks;
    int errors;

    // Reference model: samples of the open block, last total, output pending, blocks emitted.
    int m_part[$];
    int m_total;
    bit m_valid;
    int m_bcnt;
    bit m_ready;
    bit seen_ready;

    sum_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .total     (total),
        .block_cnt (block_cnt)
`ifdef SUM_ACC_AVG_EN
        ,
        .avg       (avg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // Drive one cycle of inputs, record in_ready before the edge, advance the model and the clock.
    task automatic step(input bit r, input bit c, input bit v, input int d, input bit ordy);
        int s;
        rst       = r;
        clr       = c;
        in_valid  = v;
        in_data   = d[8:0];
        out_ready = ordy;
        #1;
        seen_ready = in_ready;
        m_ready = !c && !(m_part.size() == N - 1 && m_valid && !ordy);
        if (r) begin
            m_part.delete();
            m_total = 0;
            m_valid = 0;
            m_bcnt  = 0;
        end else begin
            if (m_valid && ordy) m_valid = 0;
            if (c) begin
                m_part.delete();
            end else if (v && m_ready) begin
                m_part.push_back(d);
                if (m_part.size() == N) begin
                    s = 0;
                    foreach (m_part[i]) s += m_part[i];
                    m_total = s;
                    m_valid = 1;
                    m_bcnt  = (m_bcnt + 1) % 256;
                    m_part.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
        end
        checks++;
        if (total !== 11'd0) begin
            errors++;
            $display("FAIL reset_total: got %0d expected 0", total);
        end
        checks++;
        if (block_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_block_cnt: got %0d expected 0", block_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 1, i, 1);
            checks++;
            if (seen_ready !== 1'b1) begin
                errors++;
                $display("FAIL basic_in_ready[%0d]: got %0b expected 1", i, seen_ready);
            end
        end
        checks++;
        if (total !== 11'd10 || out_valid !== 1'b1 || block_cnt !== 8'd1) begin
            errors++;
            $display("FAIL basic_block: got total=%0d valid=%0b cnt=%0d expected 10 1 1",
                     total, out_valid, block_cnt);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_drop: got %0b expected 0", out_valid);
        end
    endtask

    task automatic test_max();
        for (int i = 0; i < 4; i++) step(0, 0, 1, 511, 1);
        checks++;
        if (total !== 11'h7FC || out_valid !== 1'b1 || block_cnt !== 8'd2) begin
            errors++;
            $display("FAIL max_block: got total=%0d valid=%0b cnt=%0d expected 2044 1 2",
                     total, out_valid, block_cnt);
        end
`ifdef SUM_ACC_AVG_EN
        checks++;
        if (avg !== 9'd511) begin
            errors++;
            $display("FAIL max_avg: got %0d expected 511", avg);
        end
`endif
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        for (int i = 1; i <= 4; i++) step(0, 0, 1, i, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 5, 0);
            checks++;
            if (seen_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_early_ready[%0d]: got %0b expected 1", i, seen_ready);
            end
        end
        step(0, 0, 1, 5, 0);
        checks++;
        if (seen_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_ready: got %0b expected 0", seen_ready);
        end
        checks++;
        if (total !== 11'd10 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got total=%0d valid=%0b expected 10 1", total, out_valid);
        end
        step(0, 0, 1, 5, 1);
        checks++;
        if (seen_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %0b expected 1", seen_ready);
        end
        checks++;
        if (total !== 11'd20 || out_valid !== 1'b1 || block_cnt !== 8'd4) begin
            errors++;
            $display("FAIL bp_release: got total=%0d valid=%0b cnt=%0d expected 20 1 4",
                     total, out_valid, block_cnt);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_valid_drop: got %0b expected 0", out_valid);
        end
    endtask

    task automatic test_clr();
        step(0, 0, 1, 7, 1);
        step(0, 0, 1, 8, 1);
        step(0, 1, 1, 9, 1);
        checks++;
        if (seen_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_in_ready: got %0b expected 0", seen_ready);
        end
        checks++;
        if (total !== 11'd20 || block_cnt !== 8'd4) begin
            errors++;
            $display("FAIL clr_keeps_output: got total=%0d cnt=%0d expected 20 4", total, block_cnt);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 1);
        checks++;
        if (total !== 11'd4 || out_valid !== 1'b1 || block_cnt !== 8'd5) begin
            errors++;
            $display("FAIL clr_next_block: got total=%0d valid=%0b cnt=%0d expected 4 1 5",
                     total, out_valid, block_cnt);
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 2, 0);
        checks++;
        if (out_valid !== 1'b1 || block_cnt !== 8'd6) begin
            errors++;
            $display("FAIL rstmid_pending: got valid=%0b cnt=%0d expected 1 6", out_valid, block_cnt);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || total !== 11'd0 || block_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_cleared: got valid=%0b total=%0d cnt=%0d expected 0 0 0",
                     out_valid, total, block_cnt);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 3, 1);
        checks++;
        if (total !== 11'd12 || out_valid !== 1'b1 || block_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rstmid_fresh_block: got total=%0d valid=%0b cnt=%0d expected 12 1 1",
                     total, out_valid, block_cnt);
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 0, 0, 1);
        for (int b = 1; b <= 256; b++) begin
            for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1);
            checks++;
            if (total !== 11'd0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap_block[%0d]: got total=%0d valid=%0b expected 0 1", b, total, out_valid);
            end
            if (b == 255) begin
                checks++;
                if (block_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_cnt_255: got %0d expected 255", block_cnt);
                end
            end
        end
        checks++;
        if (block_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_cnt_0: got %0d expected 0", block_cnt);
        end
    endtask

    task automatic test_random();
        int d;
        bit r, c, v, o;
        step(1, 0, 0, 0, 1);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 9) < 7);
            o = ($urandom_range(0, 9) < 6);
            d = ($urandom_range(0, 3) == 0) ? 511 : int'($urandom_range(0, 511));
            step(r, c, v, d, o);
            if (!r) begin
                checks++;
                if (seen_ready !== m_ready) begin
                    errors++;
                    $display("FAIL rand_in_ready@%0d: got %0b expected %0b", cyc, seen_ready, m_ready);
                end
            end
            checks++;
            if (out_valid !== m_valid) begin
                errors++;
                $display("FAIL rand_out_valid@%0d: got %0b expected %0b", cyc, out_valid, m_valid);
            end
            checks++;
            if (total !== 11'(m_total)) begin
                errors++;
                $display("FAIL rand_total@%0d: got %0d expected %0d", cyc, total, m_total);
            end
            checks++;
            if (block_cnt !== 8'(m_bcnt)) begin
                errors++;
                $display("FAIL rand_block_cnt@%0d: got %0d expected %0d", cyc, block_cnt, m_bcnt);
            end
`ifdef SUM_ACC_AVG_EN
            checks++;
            if (avg !== 9'(m_total / N)) begin
                errors++;
                $display("FAIL rand_avg@%0d: got %0d expected %0d", cyc, avg, m_total / N);
            end
`endif
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        m_total   = 0;
        m_valid   = 0;
        m_bcnt    = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_clr();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
